// File: rtl/iccm_arb_pkg.sv
// Shared definitions for the ICCM port arbiter.
//   - arb_state_e : ownership state of the single ICCM SRAM port
//   - OUTSTANDING_MAX / OCNT_W : sizing of the in-flight fetch read counter.
//     The counter is sized for the largest supported Outstanding value (3),
//     so one width serves every legal parameterisation.
package iccm_arb_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,  // fetch adapter owns the port
    DRAIN = 2'd1,  // waiting for in-flight fetch reads to return
    PROG  = 2'd2   // boot programmer owns the port
  } arb_state_e;

  localparam int OUTSTANDING_MAX = 3;
  localparam int OCNT_W          = $clog2(OUTSTANDING_MAX + 1);

endpackage

// File: rtl/iccm_port_arbiter.sv
// ICCM port arbiter: shares the single ICCM SRAM port between the TL-UL SRAM
// adapter (fetch side, read/write) and the UART boot programmer (prog side,
// write-only) with a sequenced handover instead of a static mux.
//
// Ports
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   prog_mode_i                   programming requested (level)
//   prog_req_i/addr/wdata         programmer write request
//   prog_gnt_o                    programmer write accepted this cycle
//   fetch_req_i/we/addr/wdata/wmask  adapter request
//   fetch_gnt_o                   adapter request accepted
//   fetch_rdata_o/rvalid_o        read return to adapter (no added latency)
//   mem_req/we/addr/wdata/wmask_o SRAM request side
//   mem_rdata_i/rvalid_i          SRAM read return
//   prog_active_o                 high while the programmer owns the port
//   prog_cnt_o                    words written in current/last session
//   err_o                         sticky: read data returned with none in flight
module iccm_port_arbiter
  import iccm_arb_pkg::*;
#(
  parameter int AW          = 12,
  parameter int DW          = 32,
  parameter int Outstanding = 2,
  parameter int CntW        = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              prog_mode_i,
  input  logic              prog_req_i,
  input  logic [AW-1:0]     prog_addr_i,
  input  logic [DW-1:0]     prog_wdata_i,
  output logic              prog_gnt_o,
  input  logic              fetch_req_i,
  input  logic              fetch_we_i,
  input  logic [AW-1:0]     fetch_addr_i,
  input  logic [DW-1:0]     fetch_wdata_i,
  input  logic [DW/8-1:0]   fetch_wmask_i,
  output logic              fetch_gnt_o,
  output logic [DW-1:0]     fetch_rdata_o,
  output logic              fetch_rvalid_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [AW-1:0]     mem_addr_o,
  output logic [DW-1:0]     mem_wdata_o,
  output logic [DW/8-1:0]   mem_wmask_o,
  input  logic [DW-1:0]     mem_rdata_i,
  input  logic              mem_rvalid_i,
  output logic              prog_active_o,
  output logic [CntW-1:0]   prog_cnt_o,
  output logic              err_o
);

  localparam int MW = DW / 8;
  localparam logic [OCNT_W-1:0] OCNT_LIMIT = OCNT_W'(Outstanding);
  localparam logic [OCNT_W-1:0] OCNT_ZERO  = {OCNT_W{1'b0}};
  localparam logic [OCNT_W-1:0] OCNT_ONE   = OCNT_W'(1);
  localparam logic [CntW-1:0]   PCNT_ONE   = CntW'(1);

  arb_state_e        state;
  arb_state_e        state_next;
  logic [OCNT_W-1:0] ocnt;
  logic [OCNT_W-1:0] ocnt_next;
  logic [CntW-1:0]   pcnt;
  logic              prog_active_q;
  logic              err_q;

  logic              fetch_gnt;
  logic              prog_gnt;
  logic              rd_grant;
  logic              rd_return;
  logic              slot_free;
  logic              prog_entry;

  // Grant decisions and read-return qualification.
  always_comb begin
    // A returning read frees its slot in the same cycle, so back-to-back
    // reads with single-cycle memory latency never stall.
    slot_free = (ocnt < OCNT_LIMIT) | mem_rvalid_i;
    // rst_ni gating keeps the whole memory side quiet while reset is held,
    // even though fetch_req_i may still be high.
    fetch_gnt = rst_ni & (state == FETCH) & ~prog_mode_i & fetch_req_i & slot_free;
    prog_gnt  = (state == PROG) & prog_req_i;
    rd_grant  = fetch_gnt & ~fetch_we_i;
    // A return with nothing in flight is an error and is never forwarded.
    rd_return = mem_rvalid_i & (ocnt != OCNT_ZERO);
  end

  // Outstanding read count: +1 per granted read, -1 per forwarded return.
  always_comb begin
    case ({rd_grant, rd_return})
      2'b10:   ocnt_next = ocnt + OCNT_ONE;
      2'b01:   ocnt_next = ocnt - OCNT_ONE;
      default: ocnt_next = ocnt;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= FETCH;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      FETCH: begin
        if (prog_mode_i) begin
          if (ocnt == OCNT_ZERO) begin
            state_next = PROG;
          end else begin
            state_next = DRAIN;
          end
        end else begin
          state_next = FETCH;
        end
      end
      DRAIN: begin
        if (!prog_mode_i) begin
          state_next = FETCH;
        end else if (ocnt_next == OCNT_ZERO) begin
          state_next = PROG;
        end else begin
          state_next = DRAIN;
        end
      end
      PROG: begin
        if (!prog_mode_i) begin
          state_next = FETCH;
        end else begin
          state_next = PROG;
        end
      end
      default: state_next = FETCH;
    endcase
  end

  // FSM outputs: SRAM port mux, grants and read return.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = {AW{1'b0}};
    mem_wdata_o = {DW{1'b0}};
    mem_wmask_o = {MW{1'b0}};
    if (fetch_gnt) begin
      mem_req_o   = 1'b1;
      mem_we_o    = fetch_we_i;
      mem_addr_o  = fetch_addr_i;
      mem_wdata_o = fetch_wdata_i;
      mem_wmask_o = fetch_wmask_i;
    end else if (prog_gnt) begin
      // Programmer writes are always full words.
      mem_req_o   = 1'b1;
      mem_we_o    = 1'b1;
      mem_addr_o  = prog_addr_i;
      mem_wdata_o = prog_wdata_i;
      mem_wmask_o = {MW{1'b1}};
    end else begin
      mem_req_o = 1'b0;
    end

    fetch_gnt_o    = fetch_gnt;
    prog_gnt_o     = prog_gnt;
    fetch_rvalid_o = rd_return;
    if (rd_return) begin
      fetch_rdata_o = mem_rdata_i;
    end else begin
      fetch_rdata_o = {DW{1'b0}};
    end
  end

  assign prog_entry = (state != PROG) & (state_next == PROG);

  // Outstanding read counter register; reset discards any in-flight read.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ocnt <= OCNT_ZERO;
    end else begin
      ocnt <= ocnt_next;
    end
  end

  // Programmed-word counter: cleared on session entry, held after exit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pcnt <= {CntW{1'b0}};
    end else if (prog_entry) begin
      pcnt <= {CntW{1'b0}};
    end else if (prog_gnt) begin
      pcnt <= pcnt + PCNT_ONE;
    end else begin
      pcnt <= pcnt;
    end
  end

  // Registered status: programming-active flag and sticky return error.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prog_active_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      prog_active_q <= (state_next == PROG);
      err_q         <= err_q | (mem_rvalid_i & (ocnt == OCNT_ZERO));
    end
  end

  assign prog_active_o = prog_active_q;
  assign prog_cnt_o    = pcnt;
  assign err_o         = err_q;

endmodule

// File: tb/tb_iccm_port_arbiter.sv
// Self-checking bench for iccm_port_arbiter: a behavioural model of the port
// ownership rules is compared against every DUT output on every cycle, an
// SRAM model answers reads (1-cycle or stretched latency), and directed
// sequences pin the model with literal expectations.
module tb_iccm_port_arbiter;

  localparam int AW   = 12;
  localparam int DW   = 32;
  localparam int OUTS = 2;
  localparam int CW   = 16;

  localparam int M_FETCH = 0;
  localparam int M_DRAIN = 1;
  localparam int M_PROG  = 2;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          prog_mode_i, prog_req_i;
  logic [AW-1:0] prog_addr_i;
  logic [DW-1:0] prog_wdata_i;
  logic          prog_gnt_o;
  logic          fetch_req_i, fetch_we_i;
  logic [AW-1:0] fetch_addr_i;
  logic [DW-1:0] fetch_wdata_i;
  logic [3:0]    fetch_wmask_i;
  logic          fetch_gnt_o;
  logic [DW-1:0] fetch_rdata_o;
  logic          fetch_rvalid_o;
  logic          mem_req_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [3:0]    mem_wmask_o;
  logic [DW-1:0] mem_rdata_i;
  logic          mem_rvalid_i;
  logic          prog_active_o;
  logic [CW-1:0] prog_cnt_o;
  logic          err_o;

  iccm_port_arbiter #(.AW(AW), .DW(DW), .Outstanding(OUTS), .CntW(CW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .prog_mode_i(prog_mode_i), .prog_req_i(prog_req_i),
    .prog_addr_i(prog_addr_i), .prog_wdata_i(prog_wdata_i), .prog_gnt_o(prog_gnt_o),
    .fetch_req_i(fetch_req_i), .fetch_we_i(fetch_we_i), .fetch_addr_i(fetch_addr_i),
    .fetch_wdata_i(fetch_wdata_i), .fetch_wmask_i(fetch_wmask_i),
    .fetch_gnt_o(fetch_gnt_o), .fetch_rdata_o(fetch_rdata_o), .fetch_rvalid_o(fetch_rvalid_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o),
    .mem_rdata_i(mem_rdata_i), .mem_rvalid_i(mem_rvalid_i),
    .prog_active_o(prog_active_o), .prog_cnt_o(prog_cnt_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // stimulus for the next cycle
  logic          s_pm, s_preq, s_freq, s_fwe, s_hold, s_spur;
  logic [AW-1:0] s_paddr, s_faddr;
  logic [DW-1:0] s_pwdata, s_fwdata;
  logic [3:0]    s_fwmask;

  // SRAM model
  logic [DW-1:0] mem [0:4095];
  logic [DW-1:0] rq[$];

  // behavioural model of the arbiter
  int            m_mode;
  int            m_out;
  logic [CW-1:0] m_cnt;
  logic          m_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic idle();
    s_pm = 0; s_preq = 0; s_freq = 0; s_fwe = 0; s_hold = 0; s_spur = 0;
    s_paddr = '0; s_faddr = '0; s_pwdata = '0; s_fwdata = '0; s_fwmask = 4'hF;
  endtask

  task automatic zero_inputs();
    prog_mode_i = 0; prog_req_i = 0; prog_addr_i = '0; prog_wdata_i = '0;
    fetch_req_i = 0; fetch_we_i = 0; fetch_addr_i = '0; fetch_wdata_i = '0;
    fetch_wmask_i = '0; mem_rdata_i = '0; mem_rvalid_i = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_fetch_gnt"}, fetch_gnt_o, 0);
    chk({tag, "_prog_gnt"}, prog_gnt_o, 0);
    chk({tag, "_fetch_rvalid"}, fetch_rvalid_o, 0);
    chk({tag, "_fetch_rdata"}, fetch_rdata_o, 0);
    chk({tag, "_mem_req"}, mem_req_o, 0);
    chk({tag, "_mem_we"}, mem_we_o, 0);
    chk({tag, "_mem_addr"}, mem_addr_o, 0);
    chk({tag, "_mem_wdata"}, mem_wdata_o, 0);
    chk({tag, "_mem_wmask"}, mem_wmask_o, 0);
    chk({tag, "_prog_active"}, prog_active_o, 0);
    chk({tag, "_prog_cnt"}, prog_cnt_o, 0);
    chk({tag, "_err"}, err_o, 0);
  endtask

  // Called just after a negedge, between cycles; leaves reset released at a negedge.
  task automatic reset_model_and_release();
    zero_inputs();
    rq.delete();
    m_mode = M_FETCH; m_out = 0; m_cnt = '0; m_err = 0;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  // One clock cycle: drive stimulus at negedge, compare all outputs with the
  // model, let the SRAM model react, then advance the model.
  task automatic cycle();
    logic          rv;
    logic [DW-1:0] rd;
    logic          e_fg, e_pg, e_rv, e_req, e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_rd;
    logic [3:0]    e_mask;
    int            n_out, n_mode;

    @(negedge clk_i);
    cyc++;
    prog_mode_i = s_pm; prog_req_i = s_preq; prog_addr_i = s_paddr; prog_wdata_i = s_pwdata;
    fetch_req_i = s_freq; fetch_we_i = s_fwe; fetch_addr_i = s_faddr;
    fetch_wdata_i = s_fwdata; fetch_wmask_i = s_fwmask;
    rv = 0; rd = $urandom;
    if (rq.size() > 0 && !s_hold) begin
      rv = 1; rd = rq.pop_front();
    end else if (rq.size() == 0 && s_spur) begin
      rv = 1;
    end
    mem_rvalid_i = rv;
    mem_rdata_i  = rd;
    #1;

    e_fg = (m_mode == M_FETCH) && !s_pm && s_freq && (m_out < OUTS || rv);
    e_pg = (m_mode == M_PROG) && s_preq;
    e_rv = rv && (m_out > 0);
    e_rd = e_rv ? rd : '0;
    e_req = 0; e_we = 0; e_addr = '0; e_wdata = '0; e_mask = '0;
    if (e_fg) begin
      e_req = 1; e_we = s_fwe; e_addr = s_faddr; e_wdata = s_fwdata; e_mask = s_fwmask;
    end else if (e_pg) begin
      e_req = 1; e_we = 1; e_addr = s_paddr; e_wdata = s_pwdata; e_mask = 4'hF;
    end

    chk("fetch_gnt", fetch_gnt_o, e_fg);
    chk("prog_gnt", prog_gnt_o, e_pg);
    chk("fetch_rvalid", fetch_rvalid_o, e_rv);
    chk("fetch_rdata", fetch_rdata_o, e_rd);
    chk("mem_req", mem_req_o, e_req);
    chk("mem_we", mem_we_o, e_we);
    chk("mem_addr", mem_addr_o, e_addr);
    chk("mem_wdata", mem_wdata_o, e_wdata);
    chk("mem_wmask", mem_wmask_o, e_mask);
    chk("prog_active", prog_active_o, m_mode == M_PROG);
    chk("prog_cnt", prog_cnt_o, m_cnt);
    chk("err", err_o, m_err);

    // SRAM model acts on what the DUT actually presents
    if (mem_req_o && !mem_we_o) rq.push_back(mem[mem_addr_o]);
    if (mem_req_o && mem_we_o) begin
      for (int b = 0; b < 4; b++)
        if (mem_wmask_o[b]) mem[mem_addr_o][8*b +: 8] = mem_wdata_o[8*b +: 8];
    end

    n_out = m_out + ((e_fg && !s_fwe) ? 1 : 0) - (e_rv ? 1 : 0);
    if (rv && m_out == 0) m_err = 1;
    n_mode = m_mode;
    if (m_mode == M_FETCH) begin
      if (s_pm) n_mode = (m_out == 0) ? M_PROG : M_DRAIN;
    end else if (m_mode == M_DRAIN) begin
      n_mode = !s_pm ? M_FETCH : ((n_out == 0) ? M_PROG : M_DRAIN);
    end else begin
      n_mode = s_pm ? M_PROG : M_FETCH;
    end
    if (n_mode == M_PROG && m_mode != M_PROG) m_cnt = '0;
    else if (e_pg) m_cnt = m_cnt + 1'b1;
    m_out  = n_out;
    m_mode = n_mode;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'hC0DE0000 + i;
    idle();

    // ---- power-on reset, with live requests that must stay unanswered ----
    zero_inputs();
    fetch_req_i = 1; prog_req_i = 1;
    rst_ni = 1'b0;
    #1;
    chk_reset_outputs("por");
    @(negedge clk_i);
    reset_model_and_release();

    // ---- three back-to-back fetch reads, single-cycle SRAM latency ----
    s_freq = 1; s_faddr = 12'h010; cycle();
    chk("rd0_gnt", fetch_gnt_o, 1);
    s_faddr = 12'h011; cycle();
    chk("rd1_gnt", fetch_gnt_o, 1);
    chk("rd0_data", fetch_rdata_o, 32'hC0DE0010);
    s_faddr = 12'h012; cycle();
    chk("rd2_gnt", fetch_gnt_o, 1);
    chk("rd1_data", fetch_rdata_o, 32'hC0DE0011);
    s_freq = 0; cycle();
    chk("rd2_rvalid", fetch_rvalid_o, 1);
    chk("rd2_data", fetch_rdata_o, 32'hC0DE0012);
    cycle();
    chk("rd_idle_rvalid", fetch_rvalid_o, 0);

    // ---- two reads in flight, then drain handover ----
    s_hold = 1; s_freq = 1; s_faddr = 12'h020; cycle();
    chk("dr_gnt0", fetch_gnt_o, 1);
    s_faddr = 12'h021; cycle();
    chk("dr_gnt1", fetch_gnt_o, 1);
    s_faddr = 12'h022; cycle();
    chk("dr_full_stall", fetch_gnt_o, 0);
    s_pm = 1; s_hold = 0; cycle();
    chk("dr_enter_gnt", fetch_gnt_o, 0);
    chk("dr_ret0", fetch_rdata_o, 32'hC0DE0020);
    cycle();
    chk("dr_drain_gnt", fetch_gnt_o, 0);
    chk("dr_ret1", fetch_rdata_o, 32'hC0DE0021);
    chk("dr_not_active", prog_active_o, 0);

    // ---- programming session; fetch request held throughout ----
    s_preq = 1;
    for (int i = 0; i < 4; i++) begin
      s_paddr = AW'(i); s_pwdata = 32'hDEADBEEF + i; cycle();
      chk("pg_active", prog_active_o, 1);
      chk("pg_we", mem_we_o, 1);
      chk("pg_mask", mem_wmask_o, 4'hF);
      chk("pg_fetch_blocked", fetch_gnt_o, 0);
    end
    s_preq = 0; cycle();
    chk("pg_cnt4", prog_cnt_o, 4);
    s_pm = 0; s_faddr = 12'h002; cycle();
    chk("pg_exit_blocked", fetch_gnt_o, 0);
    cycle();
    chk("pg_first_gnt", fetch_gnt_o, 1);
    chk("pg_after_inactive", prog_active_o, 0);
    s_freq = 0; cycle();
    chk("pg_readback", fetch_rdata_o, 32'hDEADBEF1);
    chk("pg_cnt_held", prog_cnt_o, 4);

    // ---- programmer request outside PROG is ignored ----
    s_preq = 1; cycle();
    chk("fe_preq_no_mem", mem_req_o, 0);
    s_preq = 0;

    // ---- spurious read return sets sticky error ----
    s_spur = 1; cycle();
    chk("er_not_fwd", fetch_rvalid_o, 0);
    s_spur = 0; cycle();
    chk("er_set", err_o, 1);

    // ---- abort during drain ----
    s_hold = 1; s_freq = 1; s_faddr = 12'h030; cycle();
    s_pm = 1; cycle();
    cycle();
    chk("ab_drain_stall", fetch_gnt_o, 0);
    s_pm = 0; cycle();
    s_hold = 0; s_freq = 0; cycle();
    chk("ab_ret", fetch_rdata_o, 32'hC0DE0030);
    chk("ab_cnt_kept", prog_cnt_o, 4);

    // ---- randomized traffic, including stretched SRAM latency ----
    idle();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(39) == 0) s_pm = ~s_pm;
      s_freq   = ($urandom_range(9) < 7);
      s_fwe    = ($urandom_range(3) == 0);
      s_faddr  = AW'($urandom_range(15));
      s_fwdata = $urandom;
      s_fwmask = 4'($urandom);
      s_preq   = $urandom_range(1);
      s_paddr  = AW'($urandom_range(15));
      s_pwdata = $urandom;
      s_hold   = ($urandom_range(3) == 0);
      s_spur   = ($urandom_range(49) == 0);
      cycle();
    end

    // ---- reset in the middle of a programming session ----
    idle();
    repeat (6) cycle();
    s_pm = 1; cycle(); cycle();
    chk("rs_in_prog", prog_active_o, 1);
    s_preq = 1; s_paddr = 12'h100; s_pwdata = 32'h11111111; cycle();
    s_paddr = 12'h101; s_pwdata = 32'h22222222; cycle();
    s_preq = 0; cycle();
    chk("rs_cnt2", prog_cnt_o, 2);
    prog_mode_i = 0; prog_req_i = 1; fetch_req_i = 1;
    rst_ni = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    @(negedge clk_i);
    reset_model_and_release();
    idle();
    cycle();
    s_freq = 1; s_faddr = 12'h101; cycle();
    chk("rs_post_gnt", fetch_gnt_o, 1);
    s_freq = 0; cycle();
    chk("rs_post_data", fetch_rdata_o, 32'h22222222);
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/iccm_port_arbiter.md
Name: iccm_port_arbiter

Overview:
- Shares the single ICCM SRAM port between two requesters: the TL-UL SRAM adapter (fetch side, read/write) and the UART boot programmer (prog side, write-only).
- Replaces the static address/write-enable mux on the programming-reset signal with a sequenced handover.
- Fetch traffic drains fully before programming starts, and the fetch path is blocked until programming ends.
- Sits between the adapter/programmer and the instruction memory top in the SoC top level.

Parameters:
- AW, 12, SRAM word-address width
- DW, 32, SRAM data width
- Outstanding, 2, max fetch reads in flight (1..3)
- CntW, 16, width of the programmed-word counter

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- prog_mode_i  in  1  programming requested (level, from ICCM programmer)
- prog_req_i  in  1  programmer write request
- prog_addr_i  in  AW  programmer word address
- prog_wdata_i  in  DW  programmer write data
- prog_gnt_o  out  1  programmer write accepted this cycle
- fetch_req_i  in  1  adapter request
- fetch_we_i  in  1  adapter write enable
- fetch_addr_i  in  AW  adapter address
- fetch_wdata_i  in  DW  adapter write data
- fetch_wmask_i  in  DW/8  adapter byte mask
- fetch_gnt_o  out  1  adapter request accepted
- fetch_rdata_o  out  DW  read data to adapter
- fetch_rvalid_o  out  1  read data valid to adapter
- mem_req_o  out  1  SRAM request
- mem_we_o  out  1  SRAM write enable
- mem_addr_o  out  AW  SRAM address
- mem_wdata_o  out  DW  SRAM write data
- mem_wmask_o  out  DW/8  SRAM byte mask
- mem_rdata_i  in  DW  SRAM read data
- mem_rvalid_i  in  1  SRAM read valid (exactly 1 cycle after accepted read)
- prog_active_o  out  1  high in PROG state
- prog_cnt_o  out  CntW  words written in current/last programming session
- err_o  out  1  sticky: mem_rvalid_i with no read outstanding

Behaviour:
- Reset values:
  - state=FETCH, outstanding count=0.
  - All outputs 0, including prog_cnt_o and err_o.
  - Reset is asynchronous and may occur mid-operation: all state returns to reset values immediately, and any in-flight read is discarded.
- States:
  - FETCH: fetch owns the port.
  - DRAIN: waiting for in-flight fetch reads to return.
  - PROG: programmer owns the port.
- Transitions:
  - FETCH->PROG when prog_mode_i=1 and outstanding=0 (same cycle as prog_mode_i seen).
  - FETCH->DRAIN when prog_mode_i=1 and outstanding>0.
  - DRAIN->PROG when outstanding reaches 0, i.e. last rvalid seen with no new grant.
  - DRAIN->FETCH if prog_mode_i drops before drain completes.
  - PROG->FETCH when prog_mode_i=0 (registered; first fetch grant possible the cycle after exit).
- fetch_gnt_o (combinational):
  - Asserted when state=FETCH, prog_mode_i=0, fetch_req_i=1, and (outstanding<Outstanding or mem_rvalid_i=1).
  - Writes consume no outstanding slot.
- prog_gnt_o = state=PROG & prog_req_i. Programmer writes are always full-word: wmask all ones, we=1.
- mem_* mux:
  - Driven by the granted requester.
  - When nothing is granted, mem_req_o=0 and the other mem_* outputs are 0.
  - mem_req_o never asserts without a grant the same cycle.
- Outstanding counter:
  - Increment on granted fetch read; decrement on mem_rvalid_i.
  - Simultaneous increment and decrement leaves the count unchanged.
  - Saturates at 0: an rvalid at 0 sets err_o and is not forwarded.
- Read return:
  - fetch_rvalid_o = mem_rvalid_i & (outstanding>0).
  - fetch_rdata_o = mem_rdata_i when fetch_rvalid_o, else 0.
  - No added latency.
- prog_cnt_o:
  - Cleared on the FETCH/DRAIN->PROG entry.
  - +1 per prog_gnt_o; wraps at 2^CntW.
  - Holds its value after PROG exit.
- prog_active_o = (state==PROG), registered.
- prog_req_i outside PROG is ignored (no grant, no memory effect). fetch_req_i in DRAIN/PROG is stalled (gnt=0), never dropped.
- err_o clears only on reset.

Decomposition:
- Package iccm_arb_pkg holds:
  - the state enum (FETCH, DRAIN, PROG);
  - the localparam for the outstanding counter width, $clog2(Outstanding+1).
- No sub-module: FSM, counters and mux fit in one 150-250 line module.

Test Plan:
- Fetch reads: fetch_req_i=1 for 3 reads at 0x010-0x012 (Outstanding=2), mem returns 1 cycle later -> gnt on all 3 with no stall (rvalid frees a slot same cycle); rdata order preserved; outstanding returns to 0.
- Drain handover: 2 reads in flight, prog_mode_i=1 -> DRAIN for 1 cycle, fetch_gnt_o=0, both rvalids forwarded, PROG the next cycle, prog_active_o=1.
- Programming: in PROG, 4 writes 0xDEADBEEF.. to 0x000-0x003 -> mem_we_o=1, wmask=0xF each, prog_cnt_o=4. Then prog_mode_i=0 -> FETCH; the read of 0x002 returns the written word.
- Blocking: fetch_req_i=1 held throughout PROG -> fetch_gnt_o=0 every PROG cycle; granted the first cycle after exit. prog_req_i in FETCH -> no mem_req_o.
- Error/abort: mem_rvalid_i pulse with 0 outstanding -> err_o=1, fetch_rvalid_o=0. prog_mode_i drop during DRAIN -> back to FETCH, prog_cnt_o unchanged.
- Reset mid-PROG after 2 writes: rst_ni low 1 cycle -> state FETCH, prog_cnt_o=0, err_o=0, all mem_* outputs 0 asynchronously.
